rx_pattern_gen: RTL and testbench

Parametrised multi-channel receive-data pattern generator for the ultrasound receive simulation path. Replaces free-running fixed-width ramp sources with a line-framed generator: on command it emits one or more scan lines of `LEN` samples on `NUM_CH` parallel ADC-like channels, with a selectable pattern, valid/first/last framing and inter-line gap. Sits in the simulation model in place of the ADC front end, feeding the receive beamformer/capture logic.

---
 rtl/rx_pattern_gen.sv | 105 ++++++++++
 tb/tb_rx_pattern_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_pattern_gen.sv
// rx_pattern_gen: line-framed multi-channel ADC-style pattern source with valid/first/last framing.
module rx_pattern_gen #(
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 8,
    parameter int LEN     = 512,
    parameter int GAP     = 4,
    parameter int CH_STEP = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     continuous,
    input  logic [1:0]               mode,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     data_valid,
    output logic                     line_first,
    output logic                     line_last,
    output logic                     busy,
    output logic [15:0]              line_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;
    localparam logic [15:0] S_LAST = 16'(LEN - 1);
    localparam logic [7:0]  G_LAST = 8'(GAP - 1);
    localparam logic [15:0] SEED   = 16'hACE1;
    state_t                   state_q, state_d;
    logic [15:0]              s_q, s_d, lfsr_q, lfsr_d, cnt_q, cnt_d;
    logic [7:0]               gap_q, gap_d;
    logic [1:0]               mode_q, mode_d;
    logic [NUM_CH*DATA_W-1:0] data_q, data_d;
    logic                     valid_q, first_q, last_q, busy_q;
    logic                     valid_d, first_d, last_d, busy_d;
    logic                     line_end, gap_end, enter;
    // Outputs are computed from next-state values so they register together with the state.
    always_comb begin
        line_end = state_q == S_RUN && s_q == S_LAST;
        gap_end  = (GAP == 0) ? line_end : (state_q == S_GAP && gap_q == G_LAST);
        enter    = (state_q == S_IDLE && start) || (gap_end && continuous);
        state_d  = state_q;
        s_d      = s_q;
        gap_d    = gap_q;
        lfsr_d   = lfsr_q;
        mode_d   = mode_q;
        if (enter) begin
            state_d = S_RUN;
            s_d     = '0;
            lfsr_d  = SEED;
            mode_d  = mode;
        end else if (gap_end) begin
            state_d = S_IDLE;
        end else if (line_end) begin
            state_d = S_GAP;
            gap_d   = '0;
        end else if (state_q == S_RUN) begin
            s_d    = s_q + 16'd1;
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end else if (state_q == S_GAP) begin
            gap_d = gap_q + 8'd1;
        end
        valid_d = state_d == S_RUN;
        busy_d  = state_d != S_IDLE;
        first_d = valid_d && s_d == '0;
        last_d  = valid_d && s_d == S_LAST;
        cnt_d   = cnt_q + {15'd0, last_d};
        data_d  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            data_d[k*DATA_W +: DATA_W] = !valid_d ? '0 :
                mode_d == 2'd3 ? {DATA_W{s_d[0]}} :
                (mode_d == 2'd0 ? s_d[DATA_W-1:0] : mode_d == 2'd2 ? lfsr_d[DATA_W-1:0] : '0)
                + DATA_W'(k * CH_STEP);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            gap_q   <= '0;
            lfsr_q  <= SEED;
            mode_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            gap_q   <= gap_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign line_first = first_q;
    assign line_last  = last_q;
    assign busy       = busy_q;
    assign line_cnt   = cnt_q;
endmodule

// File: tb/tb_rx_pattern_gen.sv
// tb_rx_pattern_gen: vector table, directed corner sequences and random run against a period-counter model.
module tb_rx_pattern_gen;
    localparam int W = 4, NC = 4, LEN = 20, GAP = 3, STEP = 1;
    localparam int NC_B = 2;
    logic clk = 1'b0, reset_n = 1'b0;
    logic start = 1'b0, continuous = 1'b0;
    logic [1:0] mode = 2'd0;
    logic start_b = 1'b0, cont_b = 1'b0;
    logic [1:0] mode_b = 2'd3;
    logic [NC*W-1:0] data_a;
    logic valid_a, first_a, last_a, busy_a;
    logic [15:0] cnt_a;
    logic [NC_B*W-1:0] data_b;
    logic valid_b, first_b, last_b, busy_b;
    logic [15:0] cnt_b;
    int n_cmp = 0, n_err = 0;
    logic [15:0] lfsr_tab [LEN];
    bit m_act;
    int m_p, m_mode;
    logic [15:0] m_cnt = '0;

    typedef struct {
        logic [1:0] m;
        int s;
        int k;
        logic [3:0] v;
        logic f;
        logic l;
    } vec_t;
    vec_t tab [14];

    always #5 clk = ~clk;

    rx_pattern_gen #(.DATA_W(W), .NUM_CH(NC), .LEN(LEN), .GAP(GAP), .CH_STEP(STEP)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous), .mode(mode),
        .data_out(data_a), .data_valid(valid_a), .line_first(first_a), .line_last(last_a),
        .busy(busy_a), .line_cnt(cnt_a));

    rx_pattern_gen #(.DATA_W(W), .NUM_CH(NC_B), .LEN(4), .GAP(0), .CH_STEP(STEP)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .continuous(cont_b), .mode(mode_b),
        .data_out(data_b), .data_valid(valid_b), .line_first(first_b), .line_last(last_b),
        .busy(busy_b), .line_cnt(cnt_b));

    // Reference: a busy line occupies a period of LEN+GAP cycles; position p < LEN is sample p.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act <= 1'b0;
            m_p   <= 0;
            m_cnt <= '0;
        end else if (!m_act) begin
            if (start) begin
                m_act  <= 1'b1;
                m_p    <= 0;
                m_mode <= int'(mode);
            end
        end else if (m_p == LEN + GAP - 1) begin
            if (continuous) begin
                m_p    <= 0;
                m_mode <= int'(mode);
            end else begin
                m_act <= 1'b0;
            end
        end else begin
            m_p <= m_p + 1;
            if (m_p + 1 == LEN - 1) m_cnt <= m_cnt + 16'd1;
        end
    end

    function automatic logic [W-1:0] pat(int m, int s, int k);
        case (m)
            0: return W'((s + k * STEP) % (1 << W));
            1: return W'((k * STEP) % (1 << W));
            2: return W'((int'(lfsr_tab[s]) + k * STEP) % (1 << W));
            default: return (s % 2 == 1) ? W'((1 << W) - 1) : W'(0);
        endcase
    endfunction

    function automatic logic [63:0] exp_vec();
        logic [NC*W-1:0] d;
        logic v, f, l;
        d = '0;
        v = m_act && m_p < LEN;
        f = v && m_p == 0;
        l = v && m_p == LEN - 1;
        for (int k = 0; k < NC; k++) if (v) d[k*W +: W] = pat(m_mode, m_p, k);
        return 64'({m_act, v, f, l, m_cnt, d});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy_a && i < 200) begin
            tick();
            i++;
        end
        check("idle_wait", 64'(busy_a), 64'd0);
    endtask

    task automatic start_line(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] r;
        logic [15:0] c0;
        int i;
        r = 16'hACE1;
        for (int s = 0; s < LEN; s++) begin
            lfsr_tab[s] = r;
            r = (r >> 1) | 16'((r[0] ^ r[2] ^ r[3] ^ r[5]) << 15);
        end
        tab[0]  = '{2'd0, 0,  0, 4'h0, 1'b1, 1'b0};
        tab[1]  = '{2'd0, 0,  3, 4'h3, 1'b1, 1'b0};
        tab[2]  = '{2'd0, 13, 3, 4'h0, 1'b0, 1'b0};
        tab[3]  = '{2'd0, 15, 0, 4'hF, 1'b0, 1'b0};
        tab[4]  = '{2'd0, 16, 0, 4'h0, 1'b0, 1'b0};
        tab[5]  = '{2'd0, 19, 1, 4'h4, 1'b0, 1'b1};
        tab[6]  = '{2'd1, 7,  2, 4'h2, 1'b0, 1'b0};
        tab[7]  = '{2'd2, 0,  0, 4'h1, 1'b1, 1'b0};
        tab[8]  = '{2'd2, 0,  1, 4'h2, 1'b1, 1'b0};
        tab[9]  = '{2'd2, 1,  0, 4'h0, 1'b0, 1'b0};
        tab[10] = '{2'd2, 2,  0, 4'h8, 1'b0, 1'b0};
        tab[11] = '{2'd3, 1,  2, 4'hF, 1'b0, 1'b0};
        tab[12] = '{2'd3, 2,  0, 4'h0, 1'b0, 1'b0};
        tab[13] = '{2'd3, 19, 3, 4'hF, 1'b0, 1'b1};

        tick();
        tick();
        check("reset_state", 64'({data_a, valid_a, first_a, last_a, busy_a, cnt_a}), 64'd0);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 14; v++) begin
            wait_idle();
            start_line(tab[v].m);
            repeat (tab[v].s) tick();
            check($sformatf("vec%0d", v), 64'({valid_a, first_a, last_a, data_a[tab[v].k*W +: W]}),
                  64'({1'b1, tab[v].f, tab[v].l, tab[v].v}));
        end

        wait_idle();
        c0 = cnt_a;
        start_line(2'd0);
        i = 0;
        while (!last_a && i < 40) begin
            tick();
            i++;
        end
        check("last_pos", 64'(i), 64'(LEN - 1));
        check("cnt_inc", 64'(cnt_a), 64'(c0 + 16'd1));
        for (int g = 0; g < GAP; g++) begin
            tick();
            check("gap_busy", 64'({busy_a, valid_a, data_a}), 64'({1'b1, 1'b0, 16'd0}));
        end
        tick();
        check("busy_drop", 64'(busy_a), 64'd0);

        start_line(2'd1);
        repeat (5) tick();
        mode = 2'd0;
        repeat (5) tick();
        check("mode_hold", 64'({valid_a, data_a[2*W +: W]}), 64'({1'b1, 4'h2}));
        wait_idle();
        start_line(2'd0);
        repeat (10) tick();
        check("mode_next", 64'({valid_a, data_a[2*W +: W]}), 64'({1'b1, 4'hC}));

        wait_idle();
        start_line(2'd0);
        repeat (8) tick();
        reset_n = 1'b0;
        #1;
        check("reset_mid", 64'({data_a, valid_a, first_a, last_a, busy_a, cnt_a}), 64'd0);
        tick();
        reset_n = 1'b1;
        start_line(2'd0);
        check("restart", 64'({valid_a, first_a, data_a[W +: W]}), 64'({1'b1, 1'b1, 4'h1}));
        check("restart_cnt", 64'(cnt_a), 64'd0);

        cont_b  = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int j = 0; j < 12; j++) begin
            check($sformatf("b2b%0d", j), 64'({valid_b, first_b, last_b, cnt_b, data_b}),
                  64'({1'b1, j % 4 == 0, j % 4 == 3, 16'((j + 1) / 4), (j % 2 == 1) ? 8'hFF : 8'h00}));
            start_b = (j == 5);
            tick();
            start_b = 1'b0;
        end
        cont_b = 1'b0;
        repeat (3) tick();
        check("b2b_final", 64'({last_b, cnt_b, data_b}), 64'({1'b1, 16'd4, 8'hFF}));
        tick();
        check("b2b_idle", 64'({busy_b, valid_b, data_b}), 64'd0);

        for (int j = 0; j < 1500; j++) begin
            start      = ($urandom_range(0, 9) == 0);
            continuous = ($urandom_range(0, 3) != 0);
            mode       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                #1;
                check("rnd_reset", 64'({data_a, valid_a, first_a, last_a, busy_a, cnt_a}), 64'd0);
                reset_n = 1'b1;
            end
            tick();
            check("rnd_model", 64'({busy_a, valid_a, first_a, last_a, cnt_a, data_a}), exp_vec());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
